cg_down_timer: RTL and testbench

Loadable countdown timer, complementary to cg_counter: cg_counter counts up from a preset default; this block counts down from a loaded value to zero.
- Signals expiry with a one-cycle pulse.
- Supports pause, abort, programmable prescale and periodic auto-reload.
- Used as the watchdog, timeout and periodic-tick source beside cg_counter in CommonGoods.

---
 rtl/cg_timer_pkg.sv | 18 +
 rtl/cg_down_timer_if.sv | 36 +++
 rtl/cg_prescaler.sv | 27 ++
 rtl/cg_down_timer.sv | 121 ++++++++++++
 tb/tb_cg_down_timer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/cg_timer_pkg.sv
// Shared types and constants for the CommonGoods down-timer.
package cg_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_RUN_ENC   = 2'd1;
  localparam logic [1:0] ST_PAUSE_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  localparam int EXPIRE_CNT_WIDTH = 8;

endpackage

// File: rtl/cg_down_timer_if.sv
// Control/status bundle of cg_down_timer; o_expire_cnt exists only with CG_DOWN_TIMER_STATUS_EN.
interface cg_down_timer_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 8
);
  logic                      i_start;
  logic                      i_stop;
  logic                      i_abort;
  logic                      i_reload_en;
  logic [DATA_WIDTH-1:0]     i_load_value;
  logic [PRESCALE_WIDTH-1:0] i_prescale;
  logic [DATA_WIDTH-1:0]     o_count;
  logic                      o_busy;
  logic                      o_expire;
`ifdef CG_DOWN_TIMER_STATUS_EN
  logic [cg_timer_pkg::EXPIRE_CNT_WIDTH-1:0] o_expire_cnt;

  modport master (
    output i_start, i_stop, i_abort, i_reload_en, i_load_value, i_prescale,
    input  o_count, o_busy, o_expire, o_expire_cnt
  );
  modport slave (
    input  i_start, i_stop, i_abort, i_reload_en, i_load_value, i_prescale,
    output o_count, o_busy, o_expire, o_expire_cnt
  );
`else
  modport master (
    output i_start, i_stop, i_abort, i_reload_en, i_load_value, i_prescale,
    input  o_count, o_busy, o_expire
  );
  modport slave (
    input  i_start, i_stop, i_abort, i_reload_en, i_load_value, i_prescale,
    output o_count, o_busy, o_expire
  );
`endif
endinterface

// File: rtl/cg_prescaler.sv
// Divider: o_tick pulses on every (i_div+1)-th enabled cycle; i_clr restarts the phase.
module cg_prescaler #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_div,
  output logic             o_tick
);
  logic [WIDTH-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == i_div);
  assign o_tick = i_en & w_wrap & ~i_clr;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/cg_down_timer.sv
// Loadable countdown timer with pause, abort, prescale and auto-reload; one-cycle o_expire pulse.
// Build with CG_DOWN_TIMER_STATUS_EN to add the saturating o_expire_cnt status output.
module cg_down_timer
  import cg_timer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int PRESCALE_WIDTH = 8
) (
  input  logic           i_clk,
  input  logic           i_rstn,
  cg_down_timer_if.slave bus
);
  timer_state_t              r_state;
  logic [DATA_WIDTH-1:0]     r_count;
  logic [DATA_WIDTH-1:0]     r_load;
  logic [PRESCALE_WIDTH-1:0] r_prescale;
  logic                      r_reload_en;
  logic                      r_busy;
  logic                      r_expire;

  logic w_active;
  logic w_pre_clr;
  logic w_pre_en;
  logic w_tick;
  logic w_expire_evt;

  assign w_active     = (r_state == RUN) || (r_state == PAUSE);
  assign w_pre_clr    = bus.i_abort | bus.i_start;
  // Leaving PAUSE counts in the same cycle, so the stall equals the stop length exactly.
  assign w_pre_en     = w_active & ~bus.i_stop & ~w_pre_clr;
  assign w_expire_evt = w_tick & (r_count <= DATA_WIDTH'(1));

  cg_prescaler #(.WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_clr  (w_pre_clr),
    .i_en   (w_pre_en),
    .i_div  (r_prescale),
    .o_tick (w_tick)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_load      <= '0;
      r_prescale  <= '0;
      r_reload_en <= 1'b0;
      r_busy      <= 1'b0;
      r_expire    <= 1'b0;
    end else begin
      r_expire <= 1'b0;
      if (bus.i_abort) begin
        r_state <= IDLE;
        r_count <= '0;
        r_busy  <= 1'b0;
      end else if (bus.i_start) begin
        r_load      <= bus.i_load_value;
        r_prescale  <= bus.i_prescale;
        r_reload_en <= bus.i_reload_en;
        r_count     <= bus.i_load_value;
        if (bus.i_load_value == '0) begin
          r_state  <= DONE;
          r_busy   <= 1'b0;
          r_expire <= 1'b1;
        end else begin
          r_state <= RUN;
          r_busy  <= 1'b1;
        end
      end else begin
        case (r_state)
          RUN, PAUSE: begin
            if (bus.i_stop) begin
              r_state <= PAUSE;
            end else begin
              r_state <= RUN;
              if (w_tick) begin
                if (!w_expire_evt) begin
                  r_count <= r_count - 1'b1;
                end else if (r_reload_en) begin
                  r_count  <= r_load;
                  r_expire <= 1'b1;
                end else begin
                  r_count  <= '0;
                  r_expire <= 1'b1;
                  r_state  <= DONE;
                  r_busy   <= 1'b0;
                end
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign bus.o_count  = r_count;
  assign bus.o_busy   = r_busy;
  assign bus.o_expire = r_expire;

`ifdef CG_DOWN_TIMER_STATUS_EN
  logic [EXPIRE_CNT_WIDTH-1:0] r_expire_cnt;

  // A zero-load start expires immediately, so that expiry is the first one counted.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_expire_cnt <= '0;
    end else if (bus.i_abort) begin
      r_expire_cnt <= '0;
    end else if (bus.i_start) begin
      r_expire_cnt <= (bus.i_load_value == '0) ? EXPIRE_CNT_WIDTH'(1) : '0;
    end else if (w_expire_evt && (r_expire_cnt != '1)) begin
      r_expire_cnt <= r_expire_cnt + 1'b1;
    end
  end

  assign bus.o_expire_cnt = r_expire_cnt;
`endif
endmodule

// File: tb/tb_cg_down_timer.sv
// Scoreboard bench: stimulus queues expected samples/expiries, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_cg_down_timer;
  logic clk;
  logic rstn;
  int   cyc;
  int   errors;
  int   checks;

  typedef struct {
    int          cyc;
    string       tag;
    logic [31:0] cnt_v;
    logic        busy;
    logic        expv;
    int          ecnt;
  } chk_t;

  chk_t chk_q[$];
  int   exp_q[$];

  cg_down_timer_if #(.DATA_WIDTH(32), .PRESCALE_WIDTH(8)) bus ();

  cg_down_timer #(.DATA_WIDTH(32), .PRESCALE_WIDTH(8)) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic expect_at(input int c, input string tag, input logic [31:0] v,
                           input logic b, input logic e, input int ec);
    chk_t t;
    t.cyc = c; t.tag = tag; t.cnt_v = v; t.busy = b; t.expv = e; t.ecnt = ec;
    chk_q.push_back(t);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns the cycle index of the edge that samples the start.
  task automatic do_start(input logic [31:0] ld, input logic [7:0] p, input logic rl,
                          output int s);
    bus.i_start      = 1'b1;
    bus.i_load_value = ld;
    bus.i_prescale   = p;
    bus.i_reload_en  = rl;
    s = cyc + 1;
    tick(1);
    bus.i_start = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    chk_t rest[$];
    rest.delete();
    for (int i = 0; i < chk_q.size(); i++) begin
      if (chk_q[i].cyc == cyc) begin
        checks++;
        if (bus.o_count !== chk_q[i].cnt_v || bus.o_busy !== chk_q[i].busy ||
            bus.o_expire !== chk_q[i].expv) begin
          errors++;
          $display("FAIL %s cyc=%0d actual count=%0d busy=%b expire=%b required count=%0d busy=%b expire=%b",
                   chk_q[i].tag, cyc, bus.o_count, bus.o_busy, bus.o_expire,
                   chk_q[i].cnt_v, chk_q[i].busy, chk_q[i].expv);
        end
`ifdef CG_DOWN_TIMER_STATUS_EN
        if (chk_q[i].ecnt >= 0) begin
          checks++;
          if (int'(bus.o_expire_cnt) != chk_q[i].ecnt) begin
            errors++;
            $display("FAIL %s_expire_cnt cyc=%0d actual=%0d required=%0d",
                     chk_q[i].tag, cyc, bus.o_expire_cnt, chk_q[i].ecnt);
          end
        end
`endif
      end else if (chk_q[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s stale_sample cyc=%0d actual=unchecked required=checked", chk_q[i].tag, chk_q[i].cyc);
      end else begin
        rest.push_back(chk_q[i]);
      end
    end
    chk_q = rest;

    while (exp_q.size() > 0 && exp_q[0] < cyc) begin
      checks++;
      errors++;
      $display("FAIL expire_missed actual=no pulse required=pulse at cyc %0d", exp_q[0]);
      void'(exp_q.pop_front());
    end
    if (bus.o_expire === 1'b1) begin
      checks++;
      if (exp_q.size() > 0 && exp_q[0] == cyc) begin
        void'(exp_q.pop_front());
      end else begin
        errors++;
        $display("FAIL expire_unexpected cyc=%0d actual=pulse required=no pulse", cyc);
      end
    end
  end

  initial begin
    int s;
    int s2;
    errors = 0;
    checks = 0;
    rstn = 1'b0;
    bus.i_start = 1'b0; bus.i_stop = 1'b0; bus.i_abort = 1'b0; bus.i_reload_en = 1'b0;
    bus.i_load_value = '0; bus.i_prescale = '0;

    tick(1);
    expect_at(cyc + 1, "reset_state", 0, 0, 0, 0);
    tick(2);
    rstn = 1'b1;

    // Plain countdown 5..0.
    do_start(5, 0, 0, s);
    for (int k = 0; k <= 5; k++)
      expect_at(s + k, "t1_count", 32'(5 - k), (k < 5), (k == 5), (k == 5) ? 1 : 0);
    expect_at(s + 6, "t1_done_hold", 0, 0, 0, 1);
    exp_q.push_back(s + 5);
    tick(8);

    // Periodic reload, load 3 prescale 3 -> pulse every 12 cycles.
    do_start(3, 3, 1, s);
    expect_at(s,      "t2_load",    3, 1, 0, 0);
    expect_at(s + 3,  "t2_presc",   3, 1, 0, 0);
    expect_at(s + 4,  "t2_tick1",   2, 1, 0, 0);
    expect_at(s + 8,  "t2_tick2",   1, 1, 0, 0);
    expect_at(s + 11, "t2_pre_exp", 1, 1, 0, 0);
    expect_at(s + 12, "t2_reload1", 3, 1, 1, 1);
    expect_at(s + 13, "t2_after1",  3, 1, 0, 1);
    expect_at(s + 16, "t2_tick4",   2, 1, 0, 1);
    expect_at(s + 24, "t2_reload2", 3, 1, 1, 2);
    expect_at(s + 36, "t2_reload3", 3, 1, 1, 3);
    exp_q.push_back(s + 12); exp_q.push_back(s + 24); exp_q.push_back(s + 36);
    tick(37);
    bus.i_abort = 1'b1;
    expect_at(s + 38, "t2_abort", 0, 0, 0, 0);
    expect_at(s + 40, "t2_idle",  0, 0, 0, 0);
    tick(1);
    bus.i_abort = 1'b0;
    tick(3);

    // Pause for 4 cycles at count 6.
    do_start(10, 0, 0, s);
    tick(4);
    for (int k = 4; k <= 8; k++) expect_at(s + k, "t3_hold", 6, 1, 0, 0);
    expect_at(s + 9,  "t3_resume", 5, 1, 0, 0);
    expect_at(s + 13, "t3_last",   1, 1, 0, 0);
    expect_at(s + 14, "t3_expire", 0, 0, 1, 1);
    expect_at(s + 15, "t3_done",   0, 0, 0, 1);
    exp_q.push_back(s + 14);
    bus.i_stop = 1'b1;
    tick(4);
    bus.i_stop = 1'b0;
    tick(8);

    // Abort at count 2, then abort racing a start.
    do_start(8, 0, 0, s);
    tick(6);
    expect_at(s + 6, "t4_count2", 2, 1, 0, 0);
    expect_at(s + 7, "t4_abort",  0, 0, 0, 0);
    expect_at(s + 8, "t4_no_exp", 0, 0, 0, 0);
    bus.i_abort = 1'b1;
    tick(1);
    bus.i_abort = 1'b0;
    tick(3);
    do_start(8, 0, 0, s);
    tick(2);
    bus.i_abort = 1'b1; bus.i_start = 1'b1; bus.i_load_value = 7;
    expect_at(s + 3, "t4_abort_wins", 0, 0, 0, 0);
    expect_at(s + 5, "t4_still_idle", 0, 0, 0, 0);
    tick(1);
    bus.i_abort = 1'b0; bus.i_start = 1'b0;
    tick(4);

    // Zero load expires immediately, with and without reload.
    do_start(0, 0, 0, s);
    expect_at(s,     "t5_zero",      0, 0, 1, 1);
    expect_at(s + 1, "t5_zero_done", 0, 0, 0, 1);
    exp_q.push_back(s);
    tick(3);
    do_start(0, 0, 1, s);
    expect_at(s,     "t5_zero_rl",      0, 0, 1, 1);
    expect_at(s + 2, "t5_zero_rl_done", 0, 0, 0, 1);
    exp_q.push_back(s);
    tick(3);

    // Reset mid-run at count 4.
    do_start(9, 0, 0, s);
    tick(5);
    expect_at(s + 5,  "t5_count4",  4, 1, 0, 0);
    expect_at(s + 6,  "t5_rst_mid", 0, 0, 0, 0);
    expect_at(s + 10, "t5_rst_idle", 0, 0, 0, 0);
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    tick(5);

    // Prescale 1 after reset: load 2 expires 4 cycles on.
    do_start(2, 1, 0, s);
    expect_at(s,     "t5_p1_load", 2, 1, 0, 0);
    expect_at(s + 1, "t5_p1_hold", 2, 1, 0, 0);
    expect_at(s + 2, "t5_p1_dec",  1, 1, 0, 0);
    expect_at(s + 4, "t5_p1_exp",  0, 0, 1, 1);
    exp_q.push_back(s + 4);
    tick(6);

    // Restart while running drops the old schedule; restart from DONE works.
    do_start(6, 0, 0, s);
    tick(2);
    do_start(5, 0, 0, s2);
    expect_at(s2,     "t5_restart",     5, 1, 0, 0);
    expect_at(s2 + 3, "t5_restart_mid", 2, 1, 0, 0);
    expect_at(s2 + 5, "t5_restart_exp", 0, 0, 1, 1);
    exp_q.push_back(s2 + 5);
    tick(7);
    do_start(2, 0, 0, s);
    expect_at(s,     "t5_from_done", 2, 1, 0, 0);
    expect_at(s + 2, "t5_done_exp",  0, 0, 1, 1);
    exp_q.push_back(s + 2);
    tick(4);

`ifdef CG_DOWN_TIMER_STATUS_EN
    // Continuous pulse train saturates the expiry counter.
    do_start(1, 0, 1, s);
    expect_at(s,       "t6_load",  1, 1, 0, 0);
    expect_at(s + 1,   "t6_first", 1, 1, 1, 1);
    expect_at(s + 255, "t6_sat",   1, 1, 1, 255);
    expect_at(s + 300, "t6_held",  1, 1, 1, 255);
    for (int k = 1; k <= 300; k++) exp_q.push_back(s + k);
    tick(300);
    do_start(4, 0, 0, s2);
    expect_at(s2,     "t6_clear", 4, 1, 0, 0);
    expect_at(s2 + 4, "t6_exp",   0, 0, 1, 1);
    exp_q.push_back(s2 + 4);
    tick(6);
`endif

    tick(3);
    while (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL expire_pending actual=no pulse required=pulse at cyc %0d", exp_q[0]);
      void'(exp_q.pop_front());
    end
    while (chk_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL %s unchecked_sample actual=unchecked required=checked at cyc %0d", chk_q[0].tag, chk_q[0].cyc);
      void'(chk_q.pop_front());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
